// File: rtl/mag_ctrl_pwm_if.sv
// rtl/mag_ctrl_pwm_if.sv - front-panel / magnetron-driver signal bundle for mag_ctrl_pwm
//
// Ports (master = panel/bench side, slave = controller side):
//   startn, stopn, clearn  active-low panel requests
//   door_closed            door interlock, 1 = closed
//   timer_done             cook timer expired (level)
//   power_level[PWR_W]     requested power, sampled on start
//   mag_on, s, r           magnetron drive and legacy SR pair
//   timer_run, done        cook timer enable, cook complete flag
//   state[2]               00 IDLE, 01 COOK, 10 PAUSED, 11 DONE
interface mag_ctrl_pwm_if #(
    parameter int PWR_W = 4
);
    logic             startn;
    logic             stopn;
    logic             clearn;
    logic             door_closed;
    logic             timer_done;
    logic [PWR_W-1:0] power_level;
    logic             mag_on;
    logic             s;
    logic             r;
    logic             timer_run;
    logic             done;
    logic [1:0]       state;

    modport master (
        output startn, stopn, clearn, door_closed, timer_done, power_level,
        input  mag_on, s, r, timer_run, done, state
    );

    modport slave (
        input  startn, stopn, clearn, door_closed, timer_done, power_level,
        output mag_on, s, r, timer_run, done, state
    );
endinterface

// File: rtl/mag_ctrl_pwm.sv
// rtl/mag_ctrl_pwm.sv - magnetron controller FSM with power-level PWM
//
// Purpose: IDLE/COOK/PAUSED/DONE controller gating a PWM of 2^PWR_W-1 steps,
// each PRESCALE clocks long, onto the magnetron drive; keeps the legacy s/r pair.
// Optional feature macro: MAG_COOLDOWN_EN (minimum magnetron off-time of
// COOL_CYCLES after a state exit turns the magnetron off).
//
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  mag_ctrl_pwm_if.slave (panel inputs in, drive/status outputs out)
module mag_ctrl_pwm #(
    parameter int PWR_W       = 4,
    parameter int PRESCALE    = 8,
    parameter int COOL_CYCLES = 64
) (
    input  logic           clk,
    input  logic           rst,
    mag_ctrl_pwm_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        COOK   = 2'b01,
        PAUSED = 2'b10,
        DONE   = 2'b11
    } state_t;

    localparam int STEPS = (1 << PWR_W) - 1;
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(PRESCALE - 1);
    localparam logic [PWR_W-1:0] STEP_MAX = PWR_W'(STEPS - 1);

    generate
        if (PRESCALE < 1 || COOL_CYCLES < 1 || PWR_W < 1) begin : g_bad_params
            $error("mag_ctrl_pwm: PRESCALE, COOL_CYCLES and PWR_W must be >= 1");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [PWR_W-1:0] level_q, level_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [PWR_W-1:0] step_q, step_d;
    logic             startn_q, startn_d;
    logic             mag_on_q, mag_on_d;
    logic             s_q, r_q;
    logic             timer_run_q, done_q;
    logic             start_evt;
    logic             start_ok;
    logic             pwm_hold;
    logic             mag_block;

`ifdef MAG_COOLDOWN_EN
    localparam int COOL_W = $clog2(COOL_CYCLES + 1);
    logic [COOL_W-1:0] cool_q, cool_d;
`endif

    always_comb begin
        startn_d  = bus.startn;
        start_evt = startn_q & ~bus.startn;
        // start only wins when no higher-priority event is active this cycle
        start_ok  = bus.clearn && bus.door_closed && bus.stopn &&
                    !bus.timer_done && start_evt;

        state_d = state_q;
        level_d = level_q;
        case (state_q)
            IDLE: begin
                if (start_ok && bus.power_level != '0) begin
                    state_d = COOK;
                    level_d = bus.power_level;
                end
            end
            COOK: begin
                if (!bus.clearn)                          state_d = IDLE;
                else if (!bus.door_closed || !bus.stopn)  state_d = PAUSED;
                else if (bus.timer_done)                  state_d = DONE;
            end
            PAUSED: begin
                if (!bus.clearn)   state_d = IDLE;
                else if (start_ok) state_d = COOK;
            end
            DONE: begin
                if (!bus.clearn || start_ok) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

`ifdef MAG_COOLDOWN_EN
        // Loaded with COOL_CYCLES on the exit edge; the drive stays blocked while
        // the count is above 1, and the PWM is frozen until it reaches 0 so the
        // first permitted on-cycle starts a full step 0.
        cool_d = (cool_q != '0) ? cool_q - 1'b1 : '0;
        if (mag_on_q && state_q == COOK && state_d != COOK)
            cool_d = COOL_W'(COOL_CYCLES);
        pwm_hold  = (cool_q != '0);
        mag_block = (cool_q > COOL_W'(1));
`else
        pwm_hold  = 1'b0;
        mag_block = 1'b0;
`endif

        // Counters run only while staying in COOK; entry and every other state clear them.
        pre_d  = '0;
        step_d = '0;
        if (state_q == COOK && state_d == COOK && !pwm_hold) begin
            if (pre_q == PRE_MAX) begin
                step_d = (step_q == STEP_MAX) ? '0 : step_q + 1'b1;
            end else begin
                pre_d  = pre_q + 1'b1;
                step_d = step_q;
            end
        end

        mag_on_d = (state_d == COOK) && (step_d < level_d) && !mag_block;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            level_q     <= '0;
            pre_q       <= '0;
            step_q      <= '0;
            startn_q    <= 1'b1;
            mag_on_q    <= 1'b0;
            s_q         <= 1'b0;
            r_q         <= 1'b1;
            timer_run_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef MAG_COOLDOWN_EN
            cool_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            pre_q       <= pre_d;
            step_q      <= step_d;
            startn_q    <= startn_d;
            mag_on_q    <= mag_on_d;
            s_q         <= mag_on_d;
            r_q         <= ~mag_on_d;
            timer_run_q <= (state_d == COOK);
            done_q      <= (state_d == DONE);
`ifdef MAG_COOLDOWN_EN
            cool_q      <= cool_d;
`endif
        end
    end

    assign bus.mag_on    = mag_on_q;
    assign bus.s         = s_q;
    assign bus.r         = r_q;
    assign bus.timer_run = timer_run_q;
    assign bus.done      = done_q;
    assign bus.state     = state_q;
endmodule

// File: doc/mag_ctrl_pwm.md
Name: mag_ctrl_pwm

Overview:
Synchronous, parametrised successor to the latch-style magnetron set/reset logic. A 4-state FSM (IDLE/COOK/PAUSED/DONE) gates a power-level PWM that drives the magnetron, with door interlock, pause/resume and a timer enable. It sits between the front-panel inputs and the magnetron driver/timer, and keeps the legacy s/r output pair for the existing SR stage.

Parameters:
PWR_W, 4, power-level width; PWM window = 2^PWR_W-1 steps; level 0 = off, level all-ones = 100 %
PRESCALE, 8, clock cycles per PWM step (>=1)
COOL_CYCLES, 64, minimum magnetron off-time in cycles (used only with MAG_COOLDOWN_EN)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
startn  in  1  start request, active low, pre-synchronised
stopn  in  1  stop/pause request, active low
clearn  in  1  cancel, active low
door_closed  in  1  door interlock, 1 = closed
timer_done  in  1  cook timer expired, level
power_level  in  PWR_W  requested power, sampled on start
mag_on  out  1  magnetron drive
s  out  1  legacy set = mag_on
r  out  1  legacy reset = ~mag_on
timer_run  out  1  cook timer count enable
done  out  1  cook complete flag
state  out  2  00 IDLE, 01 COOK, 10 PAUSED, 11 DONE

Behaviour:
- Single clock domain (clk); reset is synchronous and active-high (rst). All logic changes only on rising clk.
- Reset values: state=IDLE, mag_on=0, s=0, r=1, timer_run=0, done=0, level register=0, step counter=0, prescaler=0, startn history register=1.
- start_evt = startn high in the previous cycle and low now (falling edge, registered detector). A held-low startn produces exactly one event.
- Per-cycle event priority: clear (clearn=0) > door open (door_closed=0) > stop (stopn=0) > timer_done > start_evt.
- IDLE -> COOK on start_evt when door_closed=1, power_level!=0, timer_done=0; latch power_level into the level register. Start with level 0 is ignored.
- COOK -> IDLE on clear. COOK -> PAUSED on door open or stop. COOK -> DONE on timer_done.
- PAUSED -> IDLE on clear. PAUSED -> COOK on start_evt with door_closed=1 and stopn=1; the latched level is kept (power_level is not resampled). Otherwise PAUSED holds.
- DONE: done=1. DONE -> IDLE on clear or start_evt; a start_evt from DONE does not begin a new cook in the same cycle.
- timer_run = 1 exactly while state=COOK (registered, same cycle as state).
- PWM: in COOK, the prescaler counts 0..PRESCALE-1. On wrap, the step counter advances 0..2^PWR_W-2, then wraps to 0. The prescaler and step counter clear to 0 on every entry to COOK and in every other state.
- mag_on (registered) = (next state == COOK) && (next step < level). Latency from the qualifying input to mag_on/state change is 1 cycle. Level all-ones gives continuous on; level 1 gives on for PRESCALE cycles per window of (2^PWR_W-1)*PRESCALE cycles.
- s and r are always registered copies of mag_on and ~mag_on; never s=r.
- Door open forces mag_on=0 in the next cycle, regardless of any other input.
- rst asserted mid-cook: all outputs return to reset values on the next edge; the cook is not resumed.

Optional Feature:
MAG_COOLDOWN_EN
- Defined: a cooldown counter enforces at least COOL_CYCLES consecutive cycles with mag_on=0 after any 1->0 transition of mag_on caused by a state exit (PAUSED/DONE/IDLE). While cooling, entry to COOK is accepted (state, timer_run update) but mag_on stays 0 until the count expires; PWM steps do not advance until then. The cooldown counter resets to 0 on rst. PWM-duty off periods inside COOK do not trigger cooldown.
- Not defined: no counter is present and mag_on follows the PWM rule above immediately.

Test Plan:
- rst held 2 cycles with random inputs -> state=00, mag_on=0, s=0, r=1, timer_run=0, done=0.
- door_closed=1, power_level=4'hF, startn 1->0 -> next cycle state=01, timer_run=1, mag_on=1 continuously; assert timer_done -> next cycle state=11, done=1, mag_on=0.
- power_level=4, PRESCALE=8, cook running -> mag_on high for 32 cycles then low for 88 in every 120-cycle window.
- During COOK drop door_closed -> next cycle state=10, mag_on=0; close door and pulse startn -> state=01, same level, PWM restarts at step 0.
- Same cycle: clearn=0, stopn=0, timer_done=1 in COOK -> state=00, done=0. Start with power_level=0 -> remains IDLE.
- MAG_COOLDOWN_EN, COOL_CYCLES=64: stop then restart 10 cycles later -> state=01 immediately, mag_on stays 0 until 64 cycles after the stop, then PWM begins.
